// File: rtl/inst_fetch_buffer.sv
// Instruction fetch stage: drives the ROM address from the pc register and queues
// {pc, inst} pairs for decode behind a valid/ready handshake; redirects flush and refetch.
module inst_fetch_buffer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic [11:0] rom_addr,
  input  logic [31:0] rom_inst,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_inst,
  output logic        misaligned
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [31:0]   r_pc;
  logic [63:0]   r_mem [DEPTH];
  logic [PW-1:0] r_rd_ptr;
  logic [PW-1:0] r_wr_ptr;
  logic [CW-1:0] r_count;
  logic          r_misaligned;

  logic          w_pop;
  logic          w_push_ok;
  logic          w_push;
  logic [63:0]   w_head;

  // A full buffer still accepts a fetch when the head leaves in the same cycle.
  assign w_pop     = out_valid & out_ready;
  assign w_push_ok = (r_count < CW'(DEPTH)) | w_pop;
  assign w_push    = w_push_ok & ~redirect_valid;
  assign w_head    = r_mem[r_rd_ptr];

  assign rom_addr   = r_pc[11:0];
  assign out_valid  = (r_count != '0);
  assign out_pc     = w_head[63:32];
  assign out_inst   = w_head[31:0];
  assign misaligned = r_misaligned;

  // Control state: reset beats redirect, redirect beats push/pop.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_pc         <= RESET_PC;
      r_rd_ptr     <= '0;
      r_wr_ptr     <= '0;
      r_count      <= '0;
      r_misaligned <= 1'b0;
    end else if (redirect_valid) begin
      r_pc         <= {redirect_pc[31:2], 2'b00};
      r_rd_ptr     <= '0;
      r_wr_ptr     <= '0;
      r_count      <= '0;
      r_misaligned <= |redirect_pc[1:0];
    end else begin
      r_misaligned <= 1'b0;
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PW'(1);
        r_pc     <= r_pc + 32'd4;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Entry storage carries no reset; contents are only observed while counted valid.
  always_ff @(posedge clk) begin
    if (reset_n && w_push) begin
      r_mem[r_wr_ptr] <= {r_pc, rom_inst};
    end
  end

endmodule

// File: tb/tb_inst_fetch_buffer.sv
// Self-checking bench for inst_fetch_buffer: directed scenarios plus random traffic
// compared each cycle against a queue-based reference model.
module tb_inst_fetch_buffer;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int unsigned DEPTH    = 2;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [11:0] rom_addr;
  logic [31:0] rom_inst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_inst;
  logic        misaligned;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  logic [31:0] m_q[$];
  logic [31:0] m_pc;
  logic        m_mis;

  inst_fetch_buffer #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .rom_addr       (rom_addr),
    .rom_inst       (rom_inst),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_pc         (out_pc),
    .out_inst       (out_inst),
    .misaligned     (misaligned)
  );

  always #5 clk = ~clk;

  // ROM: word i holds i
  assign rom_inst = 32'(rom_addr[11:2]);

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_outputs();
    check_eq("valid", 64'(out_valid), 64'(m_q.size() != 0));
    check_eq("rom_addr", 64'(rom_addr), 64'(m_pc[11:0]));
    check_eq("misaligned", 64'(misaligned), 64'(m_mis));
    if (m_q.size() != 0) begin
      check_eq("out_pc", 64'(out_pc), 64'(m_q[0]));
      check_eq("out_inst", 64'(out_inst), 64'(32'(m_q[0][11:2])));
    end
  endtask

  // Advance one clock: model evolves from the pre-edge inputs, then outputs are compared.
  task automatic step();
    logic        s_rn, s_rv, s_rdy, s_pop;
    logic [31:0] s_rp;
    int          pre;
    s_rn  = reset_n;
    s_rv  = redirect_valid;
    s_rp  = redirect_pc;
    s_rdy = out_ready;
    @(posedge clk);
    #1;
    if (!s_rn) begin
      m_q.delete();
      m_pc  = RESET_PC;
      m_mis = 1'b0;
    end else if (s_rv) begin
      m_q.delete();
      m_pc  = {s_rp[31:2], 2'b00};
      m_mis = (s_rp[1:0] != 2'b00);
    end else begin
      m_mis = 1'b0;
      pre   = m_q.size();
      s_pop = (pre != 0) && s_rdy;
      if (s_pop) void'(m_q.pop_front());
      if (pre < int'(DEPTH) || s_pop) begin
        m_q.push_back(m_pc);
        m_pc = m_pc + 32'd4;
      end
    end
    check_outputs();
  endtask

  task automatic drive(input logic rn, input logic rv, input logic [31:0] rp,
                       input logic rdy, input int cycles);
    reset_n        = rn;
    redirect_valid = rv;
    redirect_pc    = rp;
    out_ready      = rdy;
    for (int i = 0; i < cycles; i++) step();
  endtask

  initial begin
    reset_n        = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    out_ready      = 1'b0;
    m_pc           = RESET_PC;
    m_mis          = 1'b0;

    // Reset state
    drive(1'b0, 1'b0, 32'h0, 1'b1, 2);
    check_eq("rst_valid", 64'(out_valid), 64'd0);
    check_eq("rst_addr", 64'(rom_addr), 64'(RESET_PC[11:0]));

    // Stream with out_ready high
    drive(1'b1, 1'b0, 32'h0, 1'b1, 1);
    check_eq("first_pc", 64'(out_pc), 64'h0);
    drive(1'b1, 1'b0, 32'h0, 1'b1, 8);

    // Backpressure fills the buffer and freezes pc
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1);
    drive(1'b1, 1'b0, 32'h0, 1'b0, 6);
    check_eq("bp_addr", 64'(rom_addr), 64'h008);
    drive(1'b1, 1'b0, 32'h0, 1'b1, 6);

    // Redirect: one bubble then target
    drive(1'b1, 1'b1, 32'h40, 1'b1, 1);
    check_eq("redir_bubble", 64'(out_valid), 64'd0);
    drive(1'b1, 1'b0, 32'h0, 1'b1, 1);
    check_eq("redir_target", 64'(out_pc), 64'h40);
    drive(1'b1, 1'b0, 32'h0, 1'b1, 3);

    // Misaligned redirect
    drive(1'b1, 1'b1, 32'h102, 1'b1, 1);
    check_eq("mis_pulse", 64'(misaligned), 64'd1);
    drive(1'b1, 1'b0, 32'h0, 1'b1, 1);
    check_eq("mis_clear", 64'(misaligned), 64'd0);
    check_eq("mis_target", 64'(out_pc), 64'h100);
    drive(1'b1, 1'b0, 32'h0, 1'b1, 2);

    // ROM address wrap
    drive(1'b1, 1'b1, 32'hFF8, 1'b1, 1);
    drive(1'b1, 1'b0, 32'h0, 1'b1, 4);

    // Reset mid-stream with a full buffer overrides a redirect
    drive(1'b1, 1'b0, 32'h0, 1'b0, 4);
    drive(1'b0, 1'b1, 32'h200, 1'b0, 1);
    check_eq("midrst_valid", 64'(out_valid), 64'd0);
    drive(1'b1, 1'b0, 32'h0, 1'b1, 1);
    check_eq("midrst_pc", 64'(out_pc), 64'(RESET_PC));
    drive(1'b1, 1'b0, 32'h0, 1'b1, 2);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] rp;
      logic        rv, rn;
      rn = ($urandom_range(0, 59) != 0);
      rv = ($urandom_range(0, 11) == 0);
      case ($urandom_range(0, 2))
        0:       rp = $urandom;
        1:       rp = 32'hFF0 + 32'($urandom_range(0, 15));
        default: rp = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
      endcase
      drive(rn, rv, rp, 1'($urandom_range(0, 1)), 1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
